nexys_starship_monster_array: RTL and testbench
===============================================

# nexys_starship_monster_array

Parametrised successor to the per-lane monster controllers in Nexys Starship: one block manages NUM_CH monster lanes (top/bottom/left/right and beyond) with shared game-level state, per-lane spawn delay and shoot timeout, a cap on simultaneously active monsters, and a saturating kill counter. It sits between the game top level (play/gameover control, random source, player shot decode) and the VGA/score display logic, replacing the per-lane controllers.

## Interface
- NUM_CH, 4: number of monster lanes (1..8).
- TIMER_W, 8: width of per-lane delay and shoot timers.
- SHOOT_LIMIT, 10: ticks a monster may stay alive before causing game over (1..2^TIMER_W-1).
- SPAWN_DELAY, 1: ticks a lane must stay empty before it may spawn (0..2^TIMER_W-1).
- MAX_ACTIVE, 2: maximum simultaneously active monsters (1..NUM_CH).
- SCORE_W, 8: kill counter width.

- Clk  input  1  system clock; one clock, all state on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- timer_tick  input  1  one-Clk-wide game-time enable; all delay/shoot counting advances only on cycles where it is 1.
- play_flag  input  1  start request from home screen.
- gameover_ctrl  input  1  external game-over (other blocks); forces OVER.
- random  input  NUM_CH  per-lane spawn request from random source.
- kill  input  NUM_CH  per-lane player hit.
- q_Init, q_Play, q_Over  output  1 each  one-hot game state.
- monster  output  NUM_CH  per-lane monster present.
- gameover  output  1  game over, registered.
- gameover_ch  output  NUM_CH  lanes whose timeout caused game over.
- active_count  output  clog2(NUM_CH+1)  number of set monster bits.
- kill_count  output  SCORE_W  kills this game, saturating.

## Operation
- Game FSM: INIT -> PLAY when play_flag=1; PLAY -> OVER on any lane timeout or gameover_ctrl=1; OVER -> INIT when play_flag=0. Illegal encoding -> INIT.
- INIT: monster, timers, delays, gameover_ch, kill_count cleared; gameover=0.
- Per lane (PLAY only), EMPTY/FULL tracked by monster[i]:
  - EMPTY: delay[i] increments on timer_tick, saturating at SPAWN_DELAY; lane armed when delay[i]==SPAWN_DELAY (SPAWN_DELAY=0: armed immediately).
  - Spawn: armed and random[i]=1 and cap allows -> monster[i]=1, timer[i]=0, delay[i]=0.
  - Cap: candidates granted in ascending lane index while active_count + grants < MAX_ACTIVE; ungranted lanes stay armed, retry later.
  - FULL: timer[i] increments on timer_tick. Timeout when tick occurs with timer[i]==SHOOT_LIMIT-1.
  - kill[i]=1 in FULL -> monster[i]=0, delay[i]=0, timer[i]=0, kill_count+1 (saturate at all-ones). kill[i] in EMPTY ignored.
  - Multiple kills same cycle: kill_count adds popcount(kill & monster), saturating.
- Kill and timeout same lane same cycle: kill wins, no game over.
- Timeout on any lane: gameover_ch records all lanes timing out that cycle, gameover=1, state OVER.
- OVER: monster, kill_count, gameover_ch frozen for display; kill/random ignored; gameover=1 held.
- gameover_ctrl in PLAY: OVER, gameover_ch=0. In INIT ignored.
- play_flag=1 and gameover_ctrl=1 in INIT: go to PLAY (gameover_ctrl ignored in INIT).

## Timing
- All outputs registered; reset values: q_Init=1, q_Play=0, q_Over=0, monster=0, gameover=0, gameover_ch=0, active_count=0, kill_count=0.
- Reset asserted any cycle (incl. mid-game) -> reset values on the next edge; dominates all inputs.
- play_flag at edge n -> q_Play=1 after edge n.
- Spawn: armed lane with random[i] at edge n -> monster[i]=1 after n; active_count updates same edge.
- Kill: kill[i] at edge n -> monster[i]=0, kill_count updated after n.
- Timeout: SHOOT_LIMIT-th tick after spawn at edge n -> gameover=1, q_Over=1 after n.
- Respawn after kill: earliest after SPAWN_DELAY ticks plus one cycle.
- timer_tick and spawn same cycle: spawn clears timer; tick not counted.

## Test plan
- Reset, play_flag=1, SPAWN_DELAY=1: one tick then random=4'b0001 -> monster=0001 next cycle, active_count=1.
- MAX_ACTIVE=2, all lanes armed, random=4'b1111 -> monster=0011; kill[0] -> next armed cycle lane 2 spawns when lane 2 rearmed, not lane 3 first.
- Lane 1 alive, 10 ticks, no kill -> gameover=1, q_Over=1, gameover_ch=0010 after 10th tick; kill thereafter ignored.
- kill[1] on same cycle as 10th tick -> no game over, monster[1]=0, kill_count=1.
- SCORE_W=2: four kills -> kill_count stays 3; two simultaneous kills at count 2 -> 3.
- Mid-PLAY Reset with monsters active -> all outputs reset values next cycle; gameover_ctrl in PLAY -> q_Over=1, gameover_ch=0.

Source files
------------

// File: rtl/nexys_starship_monster_array.sv
// Multi-lane monster controller: shared INIT/PLAY/OVER game FSM, per-lane spawn delay
// and shoot timeout, a cap on simultaneously active monsters and a saturating kill counter.
module nexys_starship_monster_array #(
    parameter int NUM_CH      = 4,
    parameter int TIMER_W     = 8,
    parameter int SHOOT_LIMIT = 10,
    parameter int SPAWN_DELAY = 1,
    parameter int MAX_ACTIVE  = 2,
    parameter int SCORE_W     = 8,
    localparam int CNT_W      = $clog2(NUM_CH + 1)
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               timer_tick,
    input  logic               play_flag,
    input  logic               gameover_ctrl,
    input  logic [NUM_CH-1:0]  random,
    input  logic [NUM_CH-1:0]  kill,
    output logic               q_Init,
    output logic               q_Play,
    output logic               q_Over,
    output logic [NUM_CH-1:0]  monster,
    output logic               gameover,
    output logic [NUM_CH-1:0]  gameover_ch,
    output logic [CNT_W-1:0]   active_count,
    output logic [SCORE_W-1:0] kill_count
);
    localparam int SUM_W = SCORE_W + CNT_W;
    localparam logic [TIMER_W-1:0] DLY      = SPAWN_DELAY[TIMER_W-1:0];
    localparam logic [TIMER_W-1:0] LIMIT_M1 = TIMER_W'(SHOOT_LIMIT - 1);
    localparam logic [CNT_W:0]     MAX_A    = MAX_ACTIVE[CNT_W:0];

    // One-hot encoding so the state register bits drive q_Init/q_Play/q_Over directly.
    typedef enum logic [2:0] {
        INIT = 3'b001,
        PLAY = 3'b010,
        OVER = 3'b100
    } state_t;

    state_t               state_q;
    logic                 go_q;
    logic [NUM_CH-1:0]    mon_q, mon_d;
    logic [NUM_CH-1:0]    goc_q;
    logic [CNT_W-1:0]     active_q, active_d;
    logic [SCORE_W-1:0]   kill_q, kill_d;
    logic [TIMER_W-1:0]   timer_q [NUM_CH];
    logic [TIMER_W-1:0]   timer_d [NUM_CH];
    logic [TIMER_W-1:0]   delay_q [NUM_CH];
    logic [TIMER_W-1:0]   delay_d [NUM_CH];
    logic [NUM_CH-1:0]    timeout;
    logic [CNT_W-1:0]     grants;
    logic [CNT_W-1:0]     kills;
    logic [SUM_W-1:0]     kill_sum;
    logic                 end_game;
    logic                 clr;

    always_comb begin
        mon_d   = mon_q;
        timeout = '0;
        grants  = '0;
        kills   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            timer_d[i] = timer_q[i];
            delay_d[i] = delay_q[i];
            if (mon_q[i]) begin
                // A kill on the timeout tick wins: the timeout branch is never reached.
                if (kill[i]) begin
                    mon_d[i]   = 1'b0;
                    timer_d[i] = '0;
                    delay_d[i] = '0;
                    kills      = kills + 1'b1;
                end else if (timer_tick) begin
                    if (timer_q[i] == LIMIT_M1) timeout[i] = 1'b1;
                    else timer_d[i] = timer_q[i] + 1'b1;
                end
            end else if (delay_q[i] == DLY && random[i] &&
                         ({1'b0, active_q} + {1'b0, grants} < MAX_A)) begin
                mon_d[i]   = 1'b1;
                timer_d[i] = '0;
                delay_d[i] = '0;
                grants     = grants + 1'b1;
            end else if (timer_tick && delay_q[i] != DLY) begin
                delay_d[i] = delay_q[i] + 1'b1;
            end
        end
        active_d = '0;
        for (int i = 0; i < NUM_CH; i++) active_d = active_d + CNT_W'(mon_d[i]);
        kill_sum = SUM_W'(kill_q) + SUM_W'(kills);
        kill_d   = (kill_sum[SUM_W-1:SCORE_W] != '0) ? '1 : kill_sum[SCORE_W-1:0];
    end

    assign end_game = (|timeout) || gameover_ctrl;
    // Lane state is wiped in INIT, on an illegal state, and on the OVER->INIT edge.
    assign clr = (state_q != PLAY) && !(state_q == OVER && play_flag);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= INIT;
            go_q    <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    go_q <= 1'b0;
                    if (play_flag) state_q <= PLAY;
                end
                PLAY: if (end_game) begin
                    state_q <= OVER;
                    go_q    <= 1'b1;
                end
                OVER: if (!play_flag) begin
                    state_q <= INIT;
                    go_q    <= 1'b0;
                end
                default: begin
                    state_q <= INIT;
                    go_q    <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset || clr) begin
            mon_q    <= '0;
            goc_q    <= '0;
            active_q <= '0;
            kill_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                timer_q[i] <= '0;
                delay_q[i] <= '0;
            end
        end else if (state_q == PLAY) begin
            mon_q    <= mon_d;
            active_q <= active_d;
            kill_q   <= kill_d;
            for (int i = 0; i < NUM_CH; i++) begin
                timer_q[i] <= timer_d[i];
                delay_q[i] <= delay_d[i];
            end
            if (end_game) goc_q <= timeout;
        end
    end

    assign q_Init       = state_q[0];
    assign q_Play       = state_q[1];
    assign q_Over       = state_q[2];
    assign monster      = mon_q;
    assign gameover     = go_q;
    assign gameover_ch  = goc_q;
    assign active_count = active_q;
    assign kill_count   = kill_q;
endmodule

// File: tb/tb_nexys_starship_monster_array.sv
// Directed bench for nexys_starship_monster_array: default instance plus a SCORE_W=2
// instance for kill counter saturation.
module tb_nexys_starship_monster_array;
    logic       clk = 1'b0;
    logic       Reset, timer_tick, play_flag, gameover_ctrl;
    logic [3:0] random, kill;
    logic       q_Init, q_Play, q_Over, gameover;
    logic [3:0] monster, gameover_ch;
    logic [2:0] active_count;
    logic [7:0] kill_count;

    logic       s_reset, s_tick, s_play, s_ctrl;
    logic [3:0] s_random, s_kill;
    logic       s_init, s_pl, s_over, s_go;
    logic [3:0] s_mon, s_goc;
    logic [2:0] s_act;
    logic [1:0] s_kc;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    nexys_starship_monster_array dut (
        .Clk(clk), .Reset(Reset), .timer_tick(timer_tick), .play_flag(play_flag),
        .gameover_ctrl(gameover_ctrl), .random(random), .kill(kill),
        .q_Init(q_Init), .q_Play(q_Play), .q_Over(q_Over), .monster(monster),
        .gameover(gameover), .gameover_ch(gameover_ch), .active_count(active_count),
        .kill_count(kill_count)
    );

    nexys_starship_monster_array #(.SCORE_W(2)) dut_sat (
        .Clk(clk), .Reset(s_reset), .timer_tick(s_tick), .play_flag(s_play),
        .gameover_ctrl(s_ctrl), .random(s_random), .kill(s_kill),
        .q_Init(s_init), .q_Play(s_pl), .q_Over(s_over), .monster(s_mon),
        .gameover(s_go), .gameover_ch(s_goc), .active_count(s_act),
        .kill_count(s_kc)
    );

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset = 1; timer_tick = 0; play_flag = 0; gameover_ctrl = 0; random = 0; kill = 0;
        s_reset = 1; s_tick = 0; s_play = 0; s_ctrl = 0; s_random = 0; s_kill = 0;
        @(negedge clk);
        cycle();
        Reset = 0;
        chk("rst_init", q_Init, 1);
        chk("rst_play", q_Play, 0);
        chk("rst_over", q_Over, 0);
        chk("rst_mon", monster, 0);
        chk("rst_go", gameover, 0);
        chk("rst_goc", gameover_ch, 0);
        chk("rst_act", active_count, 0);
        chk("rst_kc", kill_count, 0);

        play_flag = 1; cycle(); play_flag = 0;
        chk("start_play", q_Play, 1);
        chk("start_init", q_Init, 0);

        // Not armed yet: delay still 0
        random = 4'b0001; cycle(); random = 0;
        chk("unarmed_mon", monster, 4'b0000);
        timer_tick = 1; cycle(); timer_tick = 0;
        random = 4'b0001; cycle(); random = 0;
        chk("spawn0_mon", monster, 4'b0001);
        chk("spawn0_act", active_count, 1);

        // Cap of 2: only lane 1 granted
        random = 4'b1111; cycle(); random = 0;
        chk("cap_mon", monster, 4'b0011);
        chk("cap_act", active_count, 2);

        kill = 4'b0001; cycle(); kill = 0;
        chk("kill0_mon", monster, 4'b0010);
        chk("kill0_kc", kill_count, 1);
        chk("kill0_act", active_count, 1);

        // Lane 0 not rearmed; lane 2 beats lane 3
        random = 4'b1101; cycle(); random = 0;
        chk("order_mon", monster, 4'b0110);
        chk("order_act", active_count, 2);

        kill = 4'b0100; cycle(); kill = 0;
        chk("kill2_mon", monster, 4'b0010);
        chk("kill2_kc", kill_count, 2);

        kill = 4'b1000; cycle(); kill = 0;
        chk("kill_empty_kc", kill_count, 2);
        chk("kill_empty_mon", monster, 4'b0010);

        timer_tick = 1;
        for (int i = 0; i < 9; i++) cycle();
        chk("tick9_go", gameover, 0);
        chk("tick9_play", q_Play, 1);
        kill = 4'b0010; cycle(); kill = 0;
        chk("killwin_mon", monster, 4'b0000);
        chk("killwin_kc", kill_count, 3);
        chk("killwin_go", gameover, 0);
        chk("killwin_play", q_Play, 1);

        cycle();
        // Spawn together with a tick: tick must not count
        random = 4'b0010; cycle(); random = 0;
        chk("respawn_mon", monster, 4'b0010);
        chk("respawn_act", active_count, 1);
        for (int i = 0; i < 9; i++) cycle();
        chk("to9_go", gameover, 0);
        cycle();
        timer_tick = 0;
        chk("to_go", gameover, 1);
        chk("to_over", q_Over, 1);
        chk("to_play", q_Play, 0);
        chk("to_goc", gameover_ch, 4'b0010);

        play_flag = 1; kill = 4'b0010; random = 4'b1111; timer_tick = 1; cycle();
        kill = 0; random = 0; timer_tick = 0;
        chk("over_mon", monster, 4'b0010);
        chk("over_kc", kill_count, 3);
        chk("over_go", gameover, 1);
        chk("over_state", q_Over, 1);

        play_flag = 0; cycle();
        chk("back_init", q_Init, 1);
        chk("back_mon", monster, 0);
        chk("back_kc", kill_count, 0);
        chk("back_go", gameover, 0);
        chk("back_goc", gameover_ch, 0);

        gameover_ctrl = 1; cycle();
        chk("ctrl_init_hold", q_Init, 1);
        play_flag = 1; cycle(); play_flag = 0; gameover_ctrl = 0;
        chk("ctrl_init_play", q_Play, 1);
        chk("ctrl_init_over", q_Over, 0);

        timer_tick = 1; cycle(); timer_tick = 0;
        random = 4'b0011; cycle(); random = 0;
        chk("pre_rst_mon", monster, 4'b0011);
        Reset = 1; cycle(); Reset = 0;
        chk("midrst_init", q_Init, 1);
        chk("midrst_mon", monster, 0);
        chk("midrst_act", active_count, 0);
        chk("midrst_go", gameover, 0);

        play_flag = 1; cycle(); play_flag = 0;
        timer_tick = 1; cycle(); timer_tick = 0;
        random = 4'b0001; cycle(); random = 0;
        gameover_ctrl = 1; cycle(); gameover_ctrl = 0;
        chk("ctrl_over", q_Over, 1);
        chk("ctrl_go", gameover, 1);
        chk("ctrl_goc", gameover_ch, 0);
        chk("ctrl_mon", monster, 4'b0001);

        // Saturation on the 2-bit score instance
        cycle();
        s_reset = 0; s_play = 1; cycle(); s_play = 0;
        s_tick = 1; cycle(); s_tick = 0;
        s_random = 4'b0011; cycle(); s_random = 0;
        chk("sat_mon", s_mon, 4'b0011);
        s_kill = 4'b0001; cycle();
        s_kill = 4'b0010; cycle(); s_kill = 0;
        chk("sat_kc2", s_kc, 2);
        s_tick = 1; cycle(); s_tick = 0;
        s_random = 4'b0011; cycle(); s_random = 0;
        s_kill = 4'b0011; cycle(); s_kill = 0;
        chk("sat_double", s_kc, 3);
        s_tick = 1; cycle(); s_tick = 0;
        s_random = 4'b0001; cycle(); s_random = 0;
        s_kill = 4'b0001; cycle(); s_kill = 0;
        chk("sat_hold", s_kc, 3);
        chk("sat_mon_clr", s_mon, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
